// File: rtl/led_pattern_sequencer_pkg.sv
// led_pattern_sequencer_pkg: register map, mode and state encodings shared by the sequencer.
package led_pattern_sequencer_pkg;
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PERIOD  = 2'd1;
    localparam logic [1:0] REG_PATTERN = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic PHASE_ON  = 1'b0;
    localparam logic PHASE_OFF = 1'b1;
    typedef enum logic [1:0] {MODE_STATIC, MODE_ROTATE, MODE_BOUNCE, MODE_BLINK} mode_t;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COUNT, ST_WRITE} state_t;
endpackage

// File: rtl/led_pattern_sequencer_if.sv
// led_pattern_sequencer_if: Avalon-MM bus bundle; master drives writes, slave also returns readdata.
interface led_pattern_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    modport master(output address, chipselect, write_n, writedata, input waitrequest);
    modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_pattern_sequencer_step.sv
// led_pattern_step: combinational next-pattern computation for one sequencer step.
module led_pattern_step
    import led_pattern_sequencer_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             dir,
    input  logic             phase,
    input  mode_t            mode,
    output logic [WIDTH-1:0] next_cur,
    output logic             next_dir,
    output logic             next_phase
);
    always_comb begin
        // bounce reverses when the leading edge bit would fall off
        next_dir   = (mode == MODE_BOUNCE) ? dir ^ (dir ? cur[0] : cur[WIDTH-1]) : dir;
        next_phase = (mode == MODE_BLINK) ? ~phase : phase;
        next_cur   = (mode == MODE_ROTATE) ? {cur[WIDTH-2:0], cur[WIDTH-1]} :
                     (mode == MODE_BOUNCE) ? (next_dir ? cur >> 1 : cur << 1) : cur;
    end
endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: slave-configured engine issuing periodic LED pattern writes to a PIO.
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int CNT_W = 24
) (
    input logic                     clk,
    input logic                     reset,
    led_pattern_sequencer_if.slave  s,
    led_pattern_sequencer_if.master m
);
    logic             en, dir, phase, next_dir, next_phase, wr;
    mode_t            mode;
    state_t           state;
    logic [CNT_W-1:0] period, cnt, reload;
    logic [WIDTH-1:0] pattern, cur, next_cur, next_out;

    led_pattern_step #(.WIDTH(WIDTH)) step (
        .cur(cur), .dir(dir), .phase(phase), .mode(mode),
        .next_cur(next_cur), .next_dir(next_dir), .next_phase(next_phase)
    );

    assign wr       = s.chipselect & ~s.write_n;
    assign reload   = (period == '0) ? '0 : period - 1'b1;
    assign next_out = (mode == MODE_BLINK && next_phase == PHASE_OFF) ? '0 : next_cur;
    assign m.address = 2'b00;

    always_comb
        s.readdata = (s.address == REG_CTRL)    ? 32'({mode, en}) :
                     (s.address == REG_PERIOD)  ? 32'(period) :
                     (s.address == REG_PATTERN) ? 32'(pattern) :
                                                  32'({state != ST_IDLE, dir, cur});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en      <= 1'b0;
            mode    <= MODE_STATIC;
            period  <= '0;
            pattern <= '0;
        end else if (wr) begin
            if (s.address == REG_CTRL) begin
                en   <= s.writedata[0];
                mode <= mode_t'(s.writedata[2:1]);
            end
            if (s.address == REG_PERIOD) period <= s.writedata[CNT_W-1:0];
            if (s.address == REG_PATTERN) pattern <= s.writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            cur          <= '0;
            dir          <= DIR_LEFT;
            phase        <= PHASE_ON;
            m.chipselect <= 1'b0;
            m.write_n    <= 1'b1;
            m.writedata  <= '0;
        end else begin
            case (state)
                // the enabling write itself launches LOAD so the first write lands two cycles later
                ST_IDLE: if (en || (wr && s.address == REG_CTRL && s.writedata[0])) state <= ST_LOAD;
                ST_LOAD: begin
                    cur          <= pattern;
                    dir          <= DIR_LEFT;
                    phase        <= PHASE_ON;
                    cnt          <= reload;
                    m.chipselect <= 1'b1;
                    m.write_n    <= 1'b0;
                    m.writedata  <= 32'(pattern);
                    state        <= ST_WRITE;
                end
                ST_WRITE: if (!m.waitrequest) begin
                    m.chipselect <= 1'b0;
                    m.write_n    <= 1'b1;
                    state        <= en ? ST_COUNT : ST_IDLE;
                end
                ST_COUNT: begin
                    if (!en) state <= ST_IDLE;
                    else if (cnt == '0) begin
                        cur          <= next_cur;
                        dir          <= next_dir;
                        phase        <= next_phase;
                        cnt          <= reload;
                        m.chipselect <= 1'b1;
                        m.write_n    <= 1'b0;
                        m.writedata  <= 32'(next_out);
                        state        <= ST_WRITE;
                    end else cnt <= cnt - 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Avalon-MM controller that drives the 14-bit LED PIO without CPU involvement. The Nios II configures a mode, step period and seed pattern through a small slave register file. The block then issues periodic single-beat writes to the PIO data register (offset 0) through its Avalon-MM master port, producing static, shifting, bouncing or blinking LED patterns. It sits between the Nios II data master and the LED PIO slave in the Platform Designer system.

## Interface
Parameters:
- WIDTH, 14, LED pattern width; equals the PIO out_port width.
- CNT_W, 24, width of the step-period counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- s_address  in  2  register select: 0 CTRL, 1 PERIOD, 2 PATTERN, 3 STATUS.
- s_chipselect  in  1  slave select.
- s_write_n  in  1  active-low slave write strobe.
- s_writedata  in  32  slave write data.
- s_readdata  out  32  slave read data, combinational from s_address, zero-extended.
- m_address  out  2  master address; constant 0 (PIO data register).
- m_chipselect  out  1  master request.
- m_write_n  out  1  active-low master write strobe.
- m_writedata  out  32  {zeros, current pattern}.
- m_waitrequest  in  1  interconnect stall.

## Operation
- Registers:
  - CTRL[0] enable, CTRL[2:1] mode. Modes: 0 static, 1 rotate-left, 2 bounce, 3 blink.
  - PERIOD[CNT_W-1:0] is clk cycles per step; a value of 0 behaves as 1.
  - PATTERN[WIDTH-1:0] is the seed. STATUS reads {busy, dir, cur[WIDTH-1:0]} at bits [WIDTH+1], [WIDTH], [WIDTH-1:0].
- State machine: IDLE, LOAD, COUNT, WRITE.
  - IDLE: the counter is held. Go to LOAD when enable=1.
  - LOAD: cur<=PATTERN, dir<=left, phase<=on, counter<=PERIOD-1. Go to WRITE.
  - WRITE: assert m_chipselect=1 and m_write_n=0 with m_writedata={0,out}; out=cur, except in blink with phase=off, where out=0. Hold all master outputs stable while m_waitrequest=1. On the cycle with m_waitrequest=0, go to COUNT, or to IDLE if enable=0.
  - COUNT: decrement the counter. At 0, compute the next step, reload PERIOD-1, go to WRITE. Go to IDLE immediately if enable=0.
- Next step by mode:
  - static: unchanged. The write is still re-issued each period.
  - rotate: cur<={cur[WIDTH-2:0],cur[WIDTH-1]}.
  - bounce: shift in dir without wrap, zero fill. Reverse dir when the shift would lose a set bit (bit WIDTH-1 set while moving left, bit 0 set while moving right); on that step shift the other way. A cur of 0 stays 0.
  - blink: toggle phase; cur unchanged.
- Slave writes take effect on the next clock.
  - A PATTERN write while enabled updates cur only on the next LOAD.
  - A PERIOD write takes effect at the next reload.
  - A CTRL mode change takes effect at the next step computation.
- Writing enable 0→1 from IDLE triggers LOAD. A 1→1 write has no effect.
- busy=1 in every state other than IDLE.

## Timing
- Reset values: all registers 0, state IDLE, m_chipselect=0, m_write_n=1, m_writedata=0, m_address=0, dir=left, phase=on.
- Enable write at cycle t: LOAD at t+1, first master write asserted at t+2.
- With zero wait states, one write is issued every PERIOD+1 cycles: 1 WRITE cycle plus PERIOD COUNT cycles.
- If enable is cleared during WRITE, the transaction completes first; the block never aborts an Avalon write.
- Reset mid-WRITE drops the request immediately; outputs return to their reset values asynchronously.
- A slave write and a step on the same cycle: the step uses the old register value, the new value applies afterwards.

## Structure
- A shared package holds the register address constants (CTRL, PERIOD, PATTERN, STATUS), the mode encodings, and the state encoding.
- One sub-module is natural: led_pattern_step. It is purely combinational, with inputs cur, dir, phase, mode and outputs next_cur, next_dir, next_phase, and can be unit-tested standalone.

## Test plan
- Reset, then enable with mode static, PATTERN=0x0055, PERIOD=3 -> first write at t+2 with data 0x0055, repeating every 4 cycles.
- Rotate, PATTERN=0x2001, PERIOD=1 -> successive writes 0x2001, 0x0003, 0x0006.
- Bounce, PATTERN=0x2000 -> next write 0x1000 with dir right. PATTERN=0x0001 after reaching bit 0 -> 0x0002 next.
- Blink, PATTERN=0x3FFF -> writes alternate 0x3FFF, 0x0000, 0x3FFF.
- Hold m_waitrequest=1 for 5 cycles during a write and clear enable meanwhile -> master outputs stable throughout, exactly one write accepted, then IDLE with busy=0.
- Assert reset during WRITE -> m_chipselect=0 and m_write_n=1 in the same cycle; STATUS reads 0 after release.
